// File: rtl/adder_pkg.sv
// Shared adder definitions: FSM state encoding, default width
// and the majority helper used by the full-adder cells.
package adder_pkg;

  localparam int ADD_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic logic maj(
    input logic x,
    input logic y,
    input logic z
  );
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage

// File: rtl/full_adder_bit.sv
// Single-bit combinational full adder cell.
module full_adder_bit
  import adder_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = maj(a, b, cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder, LSB first, one full-adder cell plus carry flop.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.
module serial_adder
  import adder_pkg::*;
#(
  parameter  int WIDTH = ADD_WIDTH_DEF,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  state_t state;
  state_t state_nx;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] r_sr;
  logic [CNT_W-1:0] cnt;
  logic             c;
  logic             s_bit;
  logic             c_nx;
  logic             last;
  logic             load;
  logic             step;

  full_adder_bit u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (c),
    .s    (s_bit),
    .cout (c_nx)
  );

  assign last = (cnt == CNT_W'(WIDTH - 1));
  assign load = (state == ST_IDLE) && start;
  assign step = (state == ST_SHIFT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) state_nx = ST_SHIFT;
      end
      ST_SHIFT: begin
        busy = 1'b1;
        if (last) state_nx = ST_DONE;
      end
      ST_DONE: begin
        done     = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr <= '0;
      b_sr <= '0;
      r_sr <= '0;
      c    <= 1'b0;
      cnt  <= '0;
    end else if (load) begin
      a_sr <= a;
      b_sr <= b;
      r_sr <= '0;
      c    <= cin;
      cnt  <= '0;
    end else if (step) begin
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      r_sr <= {s_bit, r_sr[WIDTH-1:1]};
      c    <= c_nx;
      if (!last) cnt <= cnt + CNT_W'(1);
    end
  end

  // Results only move on the final bit so partial sums never show.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum  <= '0;
      cout <= 1'b0;
    end else if (step && last) begin
      sum  <= {s_bit, r_sr[WIDTH-1:1]};
      cout <= c_nx;
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  // c is the carry into the MSB on the final step.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (step && last) begin
      ovf <= c ^ c_nx;
    end
  end
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): directed
// cases, held start, mid-op reset and a random sweep.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
  logic         last_ovf;
`endif

  int n_err = 0;
  int n_chk = 0;

  logic [W-1:0] last_sum;
  logic         last_cout;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic int ref_total(int ia, int ib, int ic);
    return ia + ib + ic;
  endfunction

  function automatic logic ref_ovf(int ia, int ib, int ic);
    int half;
    logic c_in_msb;
    logic c_out;
    half     = 1 << (W - 1);
    c_in_msb = ((ia % half) + (ib % half) + ic) >= half;
    c_out    = (ia + ib + ic) >= (1 << W);
    return c_in_msb ^ c_out;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      check("idle.done", done, 1'b0);
      check("idle.sum", sum, last_sum);
      check("idle.cout", cout, last_cout);
    end
  endtask

  task automatic run_op(
    input logic [W-1:0] ia,
    input logic [W-1:0] ib,
    input logic         ic,
    input string        tg
  );
    int bl;
    int tot;
    a     = ia;
    b     = ib;
    cin   = ic;
    start = 1'b1;
    tick();
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    cin   = 1'($urandom);
    bl    = 0;
    for (int i = 0; i < W; i++) begin
      if (busy && !done) bl++;
      if (sum !== last_sum) bl += 100;
      tick();
    end
    tot = ref_total(int'(ia), int'(ib), int'(ic));
    check({tg, ".busy"}, bl, W);
    check({tg, ".done"}, done, 1'b1);
    check({tg, ".busy0"}, busy, 1'b0);
    check({tg, ".sum"}, sum, tot % (1 << W));
    check({tg, ".cout"}, cout, (tot >> W) & 1);
`ifdef SERIAL_ADDER_OVF_EN
    check({tg, ".ovf"}, ovf, ref_ovf(int'(ia), int'(ib), int'(ic)));
    last_ovf = ref_ovf(int'(ia), int'(ib), int'(ic));
`endif
    last_sum  = W'(tot % (1 << W));
    last_cout = 1'((tot >> W) & 1);
    tick();
    check({tg, ".pulse"}, done, 1'b0);
  endtask

  initial begin
    int ndone;
    int t1;
    int t2;
    rst       = 1'b1;
    start     = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    last_sum  = '0;
    last_cout = 1'b0;
    tick();
    tick();
    check("rst.busy", busy, 1'b0);
    check("rst.done", done, 1'b0);
    check("rst.sum", sum, 0);
    check("rst.cout", cout, 1'b0);
`ifdef SERIAL_ADDER_OVF_EN
    check("rst.ovf", ovf, 1'b0);
`endif
    rst = 1'b0;
    tick();

    run_op(8'h0F, 8'h01, 1'b0, "d0f01");
    run_op(8'hFF, 8'h00, 1'b1, "dff00");
    run_op(8'h7F, 8'h01, 1'b0, "d7f01");
    run_op(8'h80, 8'h80, 1'b0, "d8080");
    idle(2);

    // start held high: accepted only from IDLE
    a     = 8'h12;
    b     = 8'h34;
    cin   = 1'b0;
    start = 1'b1;
    ndone = 0;
    t1    = -1;
    t2    = -1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 2) begin
        a = 8'hFF;
        b = 8'h77;
      end
      if (i == 6) begin
        a = 8'h12;
        b = 8'h34;
      end
      if (done) begin
        ndone++;
        if (t1 < 0) t1 = i;
        else t2 = i;
        check("hold.sum", sum, 8'h46);
        check("hold.cout", cout, 1'b0);
      end
    end
    start = 1'b0;
    check("hold.count", ndone, 2);
    check("hold.first", t1, W);
    check("hold.gap", t2 - t1, W + 2);
    last_sum  = 8'h46;
    last_cout = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
    last_ovf = 1'b0;
`endif
    idle(2);

    // reset four cycles into SHIFT
    a     = 8'hC3;
    b     = 8'h5A;
    cin   = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    check("abort.busy_pre", busy, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort.busy", busy, 1'b0);
    check("abort.sum", sum, 0);
    check("abort.cout", cout, 1'b0);
    check("abort.done", done, 1'b0);
    last_sum  = '0;
    last_cout = 1'b0;
    idle(W + 2);
    run_op(8'h55, 8'hAA, 1'b1, "d55aa");

    for (int n = 0; n < 1000; n++) begin
      idle($urandom_range(0, 3));
      run_op(W'($urandom), W'($urandom), 1'($urandom), "rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial adder that is the additive counterpart of the team's half subtractor cells.
- Takes two WIDTH-bit operands and a carry-in with a start pulse.
- Adds one bit per clock, LSB first, through a single full-adder cell and a carry flip-flop.
- Returns sum and carry-out with a done pulse. Used where area matters more than latency, such as the ALU slow path and accumulators.

Parameters:
- WIDTH, 8, operand and sum width in bits (≥2).
- CNT_W, $clog2(WIDTH), bit-position counter width (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A; captured when start is accepted.
- b  input  WIDTH  operand B; captured when start is accepted.
- cin  input  1  carry-in; captured when start is accepted.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse; sum and cout are valid from this cycle.
- sum  output  WIDTH  registered result a+b+cin (mod 2^WIDTH).
- cout  output  1  registered carry out of bit WIDTH-1.

Behaviour:
- Reset: synchronous, active-high, dominates all other inputs.
  - Clears the state to IDLE; clears busy, done, sum, cout, the internal shift registers, the carry flip-flop and the counter.
  - A reset during SHIFT aborts the operation; no done is produced.
- States:
  - IDLE: waits for start.
  - SHIFT: adds one bit per cycle.
  - DONE: lasts exactly one cycle.
- IDLE -> SHIFT on an edge with start=1:
  - Load the a and b shift registers.
  - Load the carry flip-flop with cin.
  - Counter=0, busy=1.
- SHIFT, each edge:
  - s = a_sr[0]^b_sr[0]^c.
  - c <= majority(a_sr[0], b_sr[0], c).
  - Right-shift a_sr and b_sr; shift s into the MSB of the result shift register.
  - Counter increments.
  - On the edge where counter == WIDTH-1: go to DONE; load sum from the final result-register contents; load cout with the final carry.
- DONE:
  - done=1, busy=0.
  - The next edge returns to IDLE unconditionally.
  - start during DONE is ignored.
- start while in SHIFT or DONE is ignored; it is neither queued nor used to restart.
- Latency: start is sampled at edge k. busy is high in the cycles after edges k..k+WIDTH-1. done is high in the cycle after edge k+WIDTH. Throughput is one operation per WIDTH+2 cycles.
- sum and cout hold their last result until the next completion or reset. They never show partial values.
- Wrap-around: sum is modulo 2^WIDTH; the overflowed bit appears only on cout. Example: all-ones + 0 + cin=1 gives sum=0, cout=1.
- The counter never exceeds WIDTH-1 and returns to 0 on entry to SHIFT.
- Operand inputs may change freely after the accept edge.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), registered alongside cout.
  - ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1 (two's-complement signed overflow).
  - Captured on the final SHIFT edge; reset value 0; held like sum.
- Undefined: no ovf port and no extra flip-flop. Behaviour is otherwise identical.

Decomposition:
- Shared package adder_pkg:
  - State encoding localparams ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2.
  - Default width constant ADD_WIDTH_DEF=8.
- One natural sub-module, full_adder_bit: combinational a, b, cin -> s, cout. It is instantiated once as the serial cell and sits beside the existing half-adder/subtractor cells.
- The FSM, counter and shift registers stay in serial_adder.

Test Plan (WIDTH=8):
- Reset, then a=0x0F, b=0x01, cin=0, start at edge 0 -> busy for 8 cycles; done at cycle 9; sum=0x10, cout=0.
- a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1. With SERIAL_ADDER_OVF_EN: ovf=0.
- a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1. Then a=0x80, b=0x80 -> sum=0x00, cout=1, ovf=1.
- start held high for 20 cycles with a=0x12, b=0x34 -> exactly two completions (sum=0x46 each). The repeat is accepted only in IDLE, so done pulses are WIDTH+2 cycles apart. Changing a or b during SHIFT does not alter the result.
- rst asserted 4 cycles into SHIFT -> next cycle busy=0, sum=0, cout=0, no done. A fresh start then gives a correct result, e.g. 0x55+0xAA+1 -> sum=0x00, cout=1.
- Random sweep of 1000 operand pairs with random cin and idle gaps -> {cout,sum} == a+b+cin on every done; sum stays stable between done pulses.
